// File: rtl/kyber_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kyber_pkg
// Description : Shared Baby-Kyber constants, the coefficient type and a
//               mod-Q fold helper used by the datapath stages.
//               Q   : modulus (coefficients live in [0, Q-1])
//               N   : coefficients per polynomial
//               ETA : centred-binomial noise parameter (1 or 2)
//               QW  : coefficient width
// Revision    : 1.0 - initial release
// ============================================================================
package kyber_pkg;

    localparam int Q   = 17;
    localparam int N   = 4;
    localparam int ETA = 2;
    localparam int QW  = $clog2(Q);

    typedef logic [QW-1:0] coeff_t;

    // Folds a small signed value (|v| < Q) into the canonical range [0, Q-1].
    function automatic coeff_t mod_q_add(input logic signed [QW:0] v);
        logic signed [31:0] w_wide;
        w_wide = 32'(v);
        if (w_wide < 0) begin
            w_wide = w_wide + Q;
        end
        return coeff_t'(w_wide);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cbd_coeff_calc.sv
`default_nettype none
// ============================================================================
// Module      : cbd_coeff_calc
// Description : Combinational centred-binomial coefficient from one 2*ETA-bit
//               field: v = popcount(low ETA bits) - popcount(high ETA bits),
//               returned both as a signed value and folded mod Q.
// Ports       : i_field   in   2*ETA   random bits of one coefficient
//               o_value   out  3       signed v in [-ETA, ETA]
//               o_coeff   out  QW      v mod Q
// Revision    : 1.0 - initial release
// ============================================================================
import kyber_pkg::*;

module cbd_coeff_calc #(
    parameter int Q   = kyber_pkg::Q,
    parameter int ETA = kyber_pkg::ETA,
    parameter int QW  = $clog2(Q)
) (
    input  logic [2*ETA-1:0]   i_field,
    output logic signed [2:0]  o_value,
    output logic [QW-1:0]      o_coeff
);

    logic signed [2:0] w_pos;
    logic signed [2:0] w_neg;
    logic signed [2:0] w_v;

    always_comb begin
        w_pos = '0;
        w_neg = '0;
        for (int i = 0; i < ETA; i++) begin
            w_pos = w_pos + {2'b00, i_field[i]};
            w_neg = w_neg + {2'b00, i_field[ETA+i]};
        end
        w_v = w_pos - w_neg;
    end

    // Negative values wrap by adding Q once; |v| <= 2 so one fold suffices.
    assign o_value = w_v;
    assign o_coeff = w_v[2] ? QW'(Q + int'(w_v)) : QW'(w_v);

endmodule
`default_nettype wire

// File: rtl/cbd_noise_sampler.sv
`default_nettype none
// ============================================================================
// Module      : cbd_noise_sampler
// Description : Turns a byte stream into CBD_eta noise coefficients mod Q,
//               one per output handshake, tagging each with its index inside
//               an N-coefficient polynomial. A two-state buffer (EMPTY/FULL)
//               holds one byte; the next byte can load on the same cycle the
//               last field of the current byte is consumed, so the stream
//               runs at one coefficient per cycle.
// Ports       : clk        in   1        rising-edge clock
//               rst        in   1        asynchronous active-high reset
//               in_valid   in   1        in_byte valid
//               in_ready   out  1        byte accepted this cycle if valid
//               in_byte    in   8        random bits, LSB consumed first
//               out_valid  out  1        out_coeff valid
//               out_ready  in   1        consumer takes out_coeff
//               out_coeff  out  QW       noise coefficient mod Q
//               out_idx    out  clog2(N) index within the polynomial
//               out_signed out  3        two's complement v (only with
//                                        CBD_SIGNED_OUT_EN defined)
//               out_last   out  1        out_idx == N-1
// Config      : CBD_SIGNED_OUT_EN - adds the out_signed port.
// Revision    : 1.0 - initial release
// ============================================================================
import kyber_pkg::*;

module cbd_noise_sampler #(
    parameter int Q   = kyber_pkg::Q,
    parameter int N   = kyber_pkg::N,
    parameter int ETA = kyber_pkg::ETA,
    parameter int QW  = $clog2(Q),
    parameter int IW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_byte,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [QW-1:0]        out_coeff,
    output logic [IW-1:0]        out_idx,
`ifdef CBD_SIGNED_OUT_EN
    output logic signed [2:0]    out_signed,
`endif
    output logic                 out_last
);

    localparam int FW = 2 * ETA;
    localparam int K  = 8 / FW;
    localparam int SW = (K > 1) ? $clog2(K) : 1;

    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    logic [0:0]        r_state_q, w_state_d;
    logic [7:0]        r_byte_q,  w_byte_d;
    logic [SW-1:0]     r_sub_q,   w_sub_d;
    logic [IW-1:0]     r_idx_q,   w_idx_d;

    logic [FW-1:0]     w_field;
    logic signed [2:0] w_value;
    logic [QW-1:0]     w_coeff;
    logic              w_full;
    logic              w_last_fld;
    logic              w_out_fire;
    logic              w_in_fire;

    // Field select with constant slice bounds only.
    always_comb begin
        w_field = '0;
        for (int s = 0; s < K; s++) begin
            if (r_sub_q == SW'(s)) begin
                w_field = r_byte_q[s*FW +: FW];
            end
        end
    end

    cbd_coeff_calc #(
        .Q   (Q),
        .ETA (ETA),
        .QW  (QW)
    ) u_calc (
        .i_field (w_field),
        .o_value (w_value),
        .o_coeff (w_coeff)
    );

    assign w_full     = (r_state_q == c_ST_FULL);
    assign w_last_fld = (r_sub_q == SW'(K - 1));
    assign w_out_fire = w_full & out_ready;
    assign w_in_fire  = in_valid & in_ready;

    // Ready either when idle, or when the final field leaves this cycle.
    assign in_ready  = ~w_full | (w_last_fld & out_ready);
    assign out_valid = w_full;
    // Outputs are forced to zero while idle so they read 0 out of reset.
    assign out_coeff = w_full ? w_coeff : '0;
    assign out_idx   = r_idx_q;
    assign out_last  = w_full & (r_idx_q == IW'(N - 1));
`ifdef CBD_SIGNED_OUT_EN
    assign out_signed = w_full ? w_value : 3'sd0;
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_byte_d  = r_byte_q;
        w_sub_d   = r_sub_q;
        w_idx_d   = r_idx_q;

        if (w_out_fire) begin
            w_idx_d = (r_idx_q == IW'(N - 1)) ? '0 : r_idx_q + IW'(1);
            w_sub_d = r_sub_q + SW'(1);
            if (w_last_fld) begin
                w_sub_d   = '0;
                w_state_d = c_ST_EMPTY;
            end
        end

        // A new byte overrides the EMPTY decision above when it loads in the
        // same cycle as the last field drains.
        if (w_in_fire) begin
            w_byte_d  = in_byte;
            w_sub_d   = '0;
            w_state_d = c_ST_FULL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= c_ST_EMPTY;
            r_byte_q  <= '0;
            r_sub_q   <= '0;
            r_idx_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_byte_q  <= w_byte_d;
            r_sub_q   <= w_sub_d;
            r_idx_q   <= w_idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cbd_noise_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbd_noise_sampler
// Description : Self-checking bench for cbd_noise_sampler. Two instances
//               share the input stimulus: dut_a (ETA=2) and dut_b (ETA=1);
//               one is selected for checking at a time. Expected outputs
//               come from a queue of coefficients computed per byte from
//               the centred-binomial rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbd_noise_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_last;
    logic [4:0] a_out_coeff;
    logic [1:0] a_out_idx;
    logic       b_in_ready, b_out_valid, b_out_last;
    logic [4:0] b_out_coeff;
    logic [1:0] b_out_idx;
`ifdef CBD_SIGNED_OUT_EN
    logic signed [2:0] a_out_signed, b_out_signed;
`endif

    always #5 clk = ~clk;

    cbd_noise_sampler dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (a_in_ready),
        .in_byte    (in_byte),
        .out_valid  (a_out_valid),
        .out_ready  (out_ready),
        .out_coeff  (a_out_coeff),
        .out_idx    (a_out_idx),
`ifdef CBD_SIGNED_OUT_EN
        .out_signed (a_out_signed),
`endif
        .out_last   (a_out_last)
    );

    cbd_noise_sampler #(.ETA(1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (b_in_ready),
        .in_byte    (in_byte),
        .out_valid  (b_out_valid),
        .out_ready  (out_ready),
        .out_coeff  (b_out_coeff),
        .out_idx    (b_out_idx),
`ifdef CBD_SIGNED_OUT_EN
        .out_signed (b_out_signed),
`endif
        .out_last   (b_out_last)
    );

    typedef struct {
        int coeff;
        int idx;
        bit last;
        bit lob;     // last coefficient drawn from its byte
        int sgn;
    } exp_t;

    exp_t exp_q[$];
    int   obs_log[$];
    int   mdl_idx;
    int   sel;
    int   tests;
    int   fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Expand one byte into its coefficients: each 2*eta-bit field, LSB first,
    // gives (#ones in low half) - (#ones in high half), wrapped into [0,16].
    task automatic push_byte(input logic [7:0] b);
        int   eta;
        int   k;
        int   pa;
        int   pb;
        int   v;
        exp_t e;
        eta = (sel == 1) ? 1 : 2;
        k   = 8 / (2 * eta);
        for (int s = 0; s < k; s++) begin
            pa = 0;
            pb = 0;
            for (int j = 0; j < eta; j++) begin
                pa += int'(b[s*2*eta + j]);
                pb += int'(b[s*2*eta + eta + j]);
            end
            v       = pa - pb;
            e.coeff = (v < 0) ? v + 17 : v;
            e.sgn   = v;
            e.idx   = mdl_idx;
            e.last  = (mdl_idx == 3);
            e.lob   = (s == k - 1);
            mdl_idx = (mdl_idx + 1) % 4;
            exp_q.push_back(e);
        end
    endtask

    // One clock cycle: drive inputs, compare settled outputs, advance model.
    task automatic step(input bit iv, input logic [7:0] ib, input bit ordy, output bit acc);
        logic       ov, ir, ol;
        logic [4:0] oc;
        logic [1:0] oi;
        bit         ev, eir;
        in_valid  = iv;
        in_byte   = ib;
        out_ready = ordy;
        #1;
        ov = (sel == 1) ? b_out_valid : a_out_valid;
        ir = (sel == 1) ? b_in_ready  : a_in_ready;
        ol = (sel == 1) ? b_out_last  : a_out_last;
        oc = (sel == 1) ? b_out_coeff : a_out_coeff;
        oi = (sel == 1) ? b_out_idx   : a_out_idx;
        ev  = (exp_q.size() > 0);
        eir = !ev || (exp_q[0].lob && ordy);
        chk("out_valid", 32'(ov), 32'(ev));
        chk("in_ready", 32'(ir), 32'(eir));
        if (ev) begin
            chk("out_coeff", {27'b0, oc}, 32'(exp_q[0].coeff));
            chk("out_idx", {30'b0, oi}, 32'(exp_q[0].idx));
            chk("out_last", 32'(ol), 32'(exp_q[0].last));
`ifdef CBD_SIGNED_OUT_EN
            chk("out_signed", {29'b0, (sel == 1) ? b_out_signed : a_out_signed},
                {29'b0, 3'(exp_q[0].sgn)});
`endif
        end
        if (ov === 1'b1 && ordy) obs_log.push_back(int'(oc));
        if (ev && ordy) void'(exp_q.pop_front());
        acc = iv && eir;
        if (acc) push_byte(ib);
        @(posedge clk);
        #1;
    endtask

    // Offer bytes (held until accepted) with random valid/ready density.
    task automatic feed(input logic [7:0] bl[$], input int vpct, input int rpct, output int ncyc);
        int bi;
        bit acc;
        bit iv;
        bit rd;
        bi   = 0;
        ncyc = 0;
        while ((bi < bl.size() || exp_q.size() > 0) && ncyc < 400) begin
            iv = (bi < bl.size()) && ($urandom_range(1, 100) <= vpct);
            rd = ($urandom_range(1, 100) <= rpct);
            step(iv, iv ? bl[bi] : 8'h00, rd, acc);
            if (acc) bi++;
            ncyc++;
        end
        chk("drain_timeout", 32'(ncyc < 400), 32'd1);
        step(1'b0, 8'h00, 1'b1, acc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        exp_q.delete();
        obs_log.delete();
        mdl_idx = 0;
        chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_out_coeff", {27'b0, a_out_coeff}, 32'd0);
        chk("rst_a_out_idx", {30'b0, a_out_idx}, 32'd0);
        chk("rst_a_out_last", 32'(a_out_last), 32'd0);
        chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
        chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string tag, input int expv[$]);
        chk(tag, 32'(obs_log.size()), 32'(expv.size()));
        for (int i = 0; i < expv.size() && i < obs_log.size(); i++) begin
            chk(tag, 32'(obs_log[i]), 32'(expv[i]));
        end
    endtask

    initial begin
        logic [7:0] bl[$];
        int         e[$];
        int         ncyc;
        bit         acc;

        tests     = 0;
        fails     = 0;
        sel       = 0;
        mdl_idx   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;

        // Basic two-byte polynomial; first coefficient the cycle after accept.
        do_reset();
        bl = {8'h03, 8'hC0};
        feed(bl, 100, 100, ncyc);
        e = {2, 0, 0, 15};
        chk_log("t1_coeffs", e);
        chk("t1_cycles", 32'(ncyc), 32'd5);

        // Back-to-back streaming with no bubble.
        do_reset();
        bl = {8'h31, 8'h0C, 8'h5A, 8'h0F};
        feed(bl, 100, 100, ncyc);
        e = {1, 2, 15, 0, 0, 0, 0, 0};
        chk_log("t2_coeffs", e);
        chk("t2_cycles", 32'(ncyc), 32'd9);

        // Output stall: a competing byte is offered but must not be taken.
        do_reset();
        step(1'b1, 8'hC0, 1'b1, acc);
        for (int i = 0; i < 5; i++) step(1'b1, 8'hFF, 1'b0, acc);
        step(1'b0, 8'h00, 1'b1, acc);
        step(1'b0, 8'h00, 1'b1, acc);
        step(1'b0, 8'h00, 1'b1, acc);
        e = {0, 15};
        chk_log("t3_coeffs", e);

        // Reset in the middle of a byte discards its remainder.
        do_reset();
        step(1'b1, 8'h03, 1'b1, acc);
        step(1'b0, 8'h00, 1'b1, acc);
        do_reset();
        bl = {8'hC0};
        feed(bl, 100, 100, ncyc);
        e = {0, 15};
        chk_log("t4_coeffs", e);

        // Signed companion output (checked in step when enabled).
        do_reset();
        bl = {8'hC3};
        feed(bl, 100, 100, ncyc);
        e = {2, 15};
        chk_log("t6_coeffs", e);

        // Random bytes with random valid/ready gaps, ETA=2.
        do_reset();
        bl.delete();
        for (int i = 0; i < 24; i++) bl.push_back(8'($urandom));
        feed(bl, 70, 60, ncyc);
        chk("rand_a_count", 32'(obs_log.size()), 32'd48);

        // ETA=1 instance: fields 11,00,01,10 -> 0,0,+1,-1.
        sel = 1;
        do_reset();
        bl = {8'h93};
        feed(bl, 100, 100, ncyc);
        e = {0, 0, 1, 16};
        chk_log("t5_coeffs", e);

        do_reset();
        bl.delete();
        for (int i = 0; i < 12; i++) bl.push_back(8'($urandom));
        feed(bl, 70, 60, ncyc);
        chk("rand_b_count", 32'(obs_log.size()), 32'd48);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
